// File: rtl/bot_permute_collector.sv
// Return-side collector for bottom-permutation bursts: queues issued descriptors, checks
// result ordering against each burst's mask and emits one summed result per burst.
module bot_permute_collector #(
  parameter int EXTRA_DATA_WIDTH = 12,
  parameter int RESULT_WIDTH     = 32,
  parameter int FIFO_DEPTH_LOG2  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          burstStart,
  input  logic [5:0]                    burstValidPermutes,
  input  logic [EXTRA_DATA_WIDTH-1:0]   burstExtraData,
  output logic                          full,
  input  logic                          resultValid,
  input  logic [RESULT_WIDTH-1:0]       result,
  input  logic [2:0]                    resultPermutation,
  output logic                          sumValid,
  output logic [RESULT_WIDTH+2:0]       sum,
  output logic [EXTRA_DATA_WIDTH-1:0]   sumExtraData,
  output logic [2:0]                    sumPermuteCount,
  output logic                          protocolError,
  output logic                          overflowError
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic [FIFO_DEPTH_LOG2:0]   FULL_COUNT = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};
  localparam logic [FIFO_DEPTH_LOG2:0]   ZERO_COUNT = {(FIFO_DEPTH_LOG2+1){1'b0}};
  localparam logic [FIFO_DEPTH_LOG2:0]   ONE_COUNT  = {{FIFO_DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE    = {{(FIFO_DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [5:0]                   maskMem_r  [DEPTH];
  logic [EXTRA_DATA_WIDTH-1:0]  extraMem_r [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0]   wrPtr_r;
  logic [FIFO_DEPTH_LOG2-1:0]   rdPtr_r;
  logic [FIFO_DEPTH_LOG2-1:0]   rdPtrNext_s;
  logic [FIFO_DEPTH_LOG2:0]     occ_r;
  logic [FIFO_DEPTH_LOG2:0]     occNext_s;
  logic [5:0]                   remMask_r;
  logic [5:0]                   expBit_s;
  logic [5:0]                   clearedMask_s;
  logic [2:0]                   expIdx_s;
  logic [RESULT_WIDTH+2:0]      acc_r;
  logic [RESULT_WIDTH+2:0]      accNext_s;
  logic [2:0]                   cnt_r;
  logic                         empty_s;
  logic                         hit_s;
  logic                         lastHit_s;
  logic                         pushReq_s;
  logic                         pushOk_s;

  // The generator emits the highest remaining permutation first.
  function automatic logic [2:0] topIndex(input logic [5:0] m);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 6; i++) begin
      idx = m[i] ? i[2:0] : idx;
    end
    return idx;
  endfunction

  // Result match, retire detection and push acceptance for the current cycle.
  always_comb begin
    empty_s       = (occ_r == ZERO_COUNT);
    expIdx_s      = topIndex(remMask_r);
    expBit_s      = 6'b000001 << expIdx_s;
    clearedMask_s = remMask_r & ~expBit_s;
    hit_s         = resultValid && !empty_s && (resultPermutation == expIdx_s);
    lastHit_s     = hit_s && (clearedMask_s == 6'b000000);
    pushReq_s     = burstStart && (burstValidPermutes != 6'b000000);
    // A retiring head frees its slot in time for a same-cycle push.
    pushOk_s      = pushReq_s && ((occ_r != FULL_COUNT) || lastHit_s);
    accNext_s     = acc_r + {3'b000, result};
    rdPtrNext_s   = rdPtr_r + PTR_ONE;
    case ({pushOk_s, lastHit_s})
      2'b10:   occNext_s = occ_r + ONE_COUNT;
      2'b01:   occNext_s = occ_r - ONE_COUNT;
      default: occNext_s = occ_r;
    endcase
  end

  // Descriptor storage; contents are only read while the slot is occupied.
  always_ff @(posedge clk) begin
    if (pushOk_s) begin
      maskMem_r[wrPtr_r]  <= burstValidPermutes;
      extraMem_r[wrPtr_r] <= burstExtraData;
    end
  end

  // Pointers, head working mask, accumulator, aggregate output and sticky errors.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_r         <= {FIFO_DEPTH_LOG2{1'b0}};
      rdPtr_r         <= {FIFO_DEPTH_LOG2{1'b0}};
      occ_r           <= ZERO_COUNT;
      full            <= 1'b0;
      remMask_r       <= 6'b000000;
      acc_r           <= {(RESULT_WIDTH+3){1'b0}};
      cnt_r           <= 3'd0;
      sumValid        <= 1'b0;
      sum             <= {(RESULT_WIDTH+3){1'b0}};
      sumExtraData    <= {EXTRA_DATA_WIDTH{1'b0}};
      sumPermuteCount <= 3'd0;
      protocolError   <= 1'b0;
      overflowError   <= 1'b0;
    end else begin
      sumValid <= 1'b0;
      occ_r    <= occNext_s;
      full     <= (occNext_s == FULL_COUNT);
      if (resultValid && !hit_s) begin
        protocolError <= 1'b1;
      end
      if (pushReq_s && !pushOk_s) begin
        overflowError <= 1'b1;
      end
      if (pushOk_s) begin
        wrPtr_r <= wrPtr_r + PTR_ONE;
      end
      if (lastHit_s) begin
        rdPtr_r         <= rdPtrNext_s;
        sumValid        <= 1'b1;
        sum             <= accNext_s;
        sumExtraData    <= extraMem_r[rdPtr_r];
        sumPermuteCount <= cnt_r + 3'd1;
        acc_r           <= {(RESULT_WIDTH+3){1'b0}};
        cnt_r           <= 3'd0;
        // Next head is an older queued entry, or the descriptor arriving this cycle.
        if (occ_r > ONE_COUNT) begin
          remMask_r <= maskMem_r[rdPtrNext_s];
        end else if (pushOk_s) begin
          remMask_r <= burstValidPermutes;
        end else begin
          remMask_r <= 6'b000000;
        end
      end else if (hit_s) begin
        remMask_r <= clearedMask_s;
        acc_r     <= accNext_s;
        cnt_r     <= cnt_r + 3'd1;
      end else if (empty_s && pushOk_s) begin
        remMask_r <= burstValidPermutes;
      end else begin
        remMask_r <= remMask_r;
      end
    end
  end

endmodule

// File: tb/tb_bot_permute_collector.sv
// Self-checking bench for bot_permute_collector: queue-based burst model plus directed literals.
module tb_bot_permute_collector;
  localparam int EW = 12;
  localparam int RW = 32;
  localparam int L2 = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          burstStart = 1'b0;
  logic [5:0]    burstValidPermutes = 6'd0;
  logic [EW-1:0] burstExtraData = '0;
  logic          full;
  logic          resultValid = 1'b0;
  logic [RW-1:0] result = '0;
  logic [2:0]    resultPermutation = 3'd0;
  logic          sumValid;
  logic [RW+2:0] sum;
  logic [EW-1:0] sumExtraData;
  logic [2:0]    sumPermuteCount;
  logic          protocolError;
  logic          overflowError;

  bot_permute_collector #(.EXTRA_DATA_WIDTH(EW), .RESULT_WIDTH(RW), .FIFO_DEPTH_LOG2(L2)) dut (
    .clk(clk), .rst(rst), .burstStart(burstStart), .burstValidPermutes(burstValidPermutes),
    .burstExtraData(burstExtraData), .full(full), .resultValid(resultValid), .result(result),
    .resultPermutation(resultPermutation), .sumValid(sumValid), .sum(sum),
    .sumExtraData(sumExtraData), .sumPermuteCount(sumPermuteCount),
    .protocolError(protocolError), .overflowError(overflowError)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Behavioural model: queue of outstanding bursts (remaining mask + extra data).
  logic [5:0]    mMask [$];
  logic [EW-1:0] mExtra [$];
  logic [RW+2:0] mAcc;
  int            mCnt;
  logic          eSumValid;
  logic [RW+2:0] eSum;
  logic [EW-1:0] eExtra;
  int            eCnt;
  logic          eProt;
  logic          eOvf;
  logic          eFull;

  function automatic int topOf(input logic [5:0] m);
    for (int i = 5; i >= 0; i--) if (m[i]) return i;
    return -1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mMask.delete();
    mExtra.delete();
    mAcc = '0; mCnt = 0;
    eSumValid = 1'b0; eSum = '0; eExtra = '0; eCnt = 0;
    eProt = 1'b0; eOvf = 1'b0; eFull = 1'b0;
  endtask

  task automatic modelStep(input logic bs, input logic [5:0] mk, input logic [EW-1:0] ex,
                           input logic rv, input logic [RW-1:0] rs, input logic [2:0] pm);
    logic [5:0] rem;
    int t;
    eSumValid = 1'b0;
    if (rv) begin
      if (mMask.size() == 0) eProt = 1'b1;
      else begin
        rem = mMask[0];
        t = topOf(rem);
        if (int'(pm) != t) eProt = 1'b1;
        else begin
          rem[t] = 1'b0;
          mMask[0] = rem;
          mAcc = mAcc + {3'b000, rs};
          mCnt++;
          if (rem == 6'd0) begin
            eSumValid = 1'b1; eSum = mAcc; eExtra = mExtra[0]; eCnt = mCnt;
            void'(mMask.pop_front());
            void'(mExtra.pop_front());
            mAcc = '0; mCnt = 0;
          end
        end
      end
    end
    if (bs && mk != 6'd0) begin
      if (mMask.size() >= 16) eOvf = 1'b1;
      else begin
        mMask.push_back(mk);
        mExtra.push_back(ex);
      end
    end
    eFull = (mMask.size() == 16);
  endtask

  task automatic cycle(input logic bs, input logic [5:0] mk, input logic [EW-1:0] ex,
                       input logic rv, input logic [RW-1:0] rs, input logic [2:0] pm);
    burstStart = bs; burstValidPermutes = mk; burstExtraData = ex;
    resultValid = rv; result = rs; resultPermutation = pm;
    @(posedge clk);
    if (!rst) modelStep(bs, mk, ex, rv, rs, pm);
    @(negedge clk);
  endtask

  task automatic push(input logic [5:0] mk, input logic [EW-1:0] ex);
    cycle(1'b1, mk, ex, 1'b0, '0, 3'd0);
  endtask

  task automatic res(input logic [2:0] pm, input logic [RW-1:0] v);
    cycle(1'b0, 6'd0, '0, 1'b1, v, pm);
  endtask

  task automatic doReset();
    #1;
    rst = 1'b1;
    burstStart = 1'b0; resultValid = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst) begin
      check("sumValid", sumValid, eSumValid);
      if (eSumValid) begin
        check("sum", sum, eSum);
        check("sumExtraData", sumExtraData, eExtra);
        check("sumPermuteCount", sumPermuteCount, eCnt);
      end
      check("protocolError", protocolError, eProt);
      check("overflowError", overflowError, eOvf);
      check("full", full, eFull);
    end
  end

  initial begin
    logic [2:0] pm;
    modelReset();
    doReset();
    check("reset_sum", sum, 0);
    check("reset_full", full, 0);

    // Three-result burst
    push(6'b101001, 12'h3A5);
    res(3'd5, 32'd10);
    res(3'd3, 32'd20);
    check("t1_no_early_pulse", sumValid, 0);
    res(3'd0, 32'd30);
    check("t1_valid", sumValid, 1);
    check("t1_sum", sum, 60);
    check("t1_extra", sumExtraData, 12'h3A5);
    check("t1_count", sumPermuteCount, 3);
    cycle(1'b0, 6'd0, '0, 1'b0, '0, 3'd0);
    check("t1_single_pulse", sumValid, 0);

    // Full mask, single-bit mask, ignored empty mask
    push(6'b111111, 12'h111);
    push(6'b000001, 12'h222);
    push(6'b000000, 12'h333);
    for (int i = 0; i < 6; i++) res(3'(5 - i), 32'(i + 1));
    check("t2_sum_a", sum, 21);
    check("t2_count_a", sumPermuteCount, 6);
    check("t2_extra_a", sumExtraData, 12'h111);
    res(3'd0, 32'd7);
    check("t2_sum_b", sum, 7);
    check("t2_count_b", sumPermuteCount, 1);
    check("t2_extra_b", sumExtraData, 12'h222);
    res(3'd0, 32'd9);
    check("t2_empty_mask_ignored", protocolError, 1);

    // Out-of-order result is discarded
    doReset();
    push(6'b110000, 12'h055);
    res(3'd4, 32'd5);
    check("t3_protocolError", protocolError, 1);
    res(3'd5, 32'd5);
    check("t3_pending", sumValid, 0);
    check("t3_model_next_idx", topOf(mMask[0]), 4);
    res(3'd4, 32'd8);
    check("t3_sum", sum, 13);
    check("t3_count", sumPermuteCount, 2);

    // Fill, overflow, retire-while-full
    doReset();
    for (int i = 0; i < 16; i++) push(6'b000001, 12'(i + 1));
    check("t4_full", full, 1);
    check("t4_no_ovf_yet", overflowError, 0);
    push(6'b000001, 12'hFFF);
    check("t4_overflow", overflowError, 1);
    cycle(1'b1, 6'b000001, 12'h077, 1'b1, 32'd42, 3'd0);
    check("t4_pop_sum", sum, 42);
    check("t4_pop_extra", sumExtraData, 12'h001);
    check("t4_full_stays", full, 1);

    // Maximum values without truncation
    doReset();
    push(6'b111111, 12'h0AA);
    for (int i = 0; i < 6; i++) res(3'(5 - i), 32'hFFFF_FFFF);
    check("t5_max_sum", sum, 35'h5_FFFF_FFFA);
    check("t5_count", sumPermuteCount, 6);

    // Reset mid-burst
    doReset();
    push(6'b000111, 12'h123);
    res(3'd2, 32'd100);
    res(3'd1, 32'd200);
    doReset();
    check("t6_no_pulse", sumValid, 0);
    check("t6_prot", protocolError, 0);
    check("t6_ovf", overflowError, 0);
    check("t6_full", full, 0);
    res(3'd0, 32'd300);
    check("t6_empty_after_reset", protocolError, 1);
    doReset();
    push(6'b000001, 12'h456);
    res(3'd0, 32'd9);
    check("t6_fresh_sum", sum, 9);

    // Randomised traffic
    doReset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) doReset();
      if (mMask.size() > 0 && $urandom_range(0, 99) < 97) pm = 3'(topOf(mMask[0]));
      else pm = 3'($urandom_range(0, 7));
      cycle($urandom_range(0, 99) < 35, 6'($urandom_range(0, 63)), EW'($urandom),
            $urandom_range(0, 99) < 60, $urandom, pm);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
